// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_TX_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_TICKS = 160,
  parameter int GUARD_TICKS = 16,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_tx,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  output logic                 o_busy,
  output logic [ID_W-1:0]      o_grant_id
);

  localparam int MAX_TICKS = (FRAME_TICKS > GUARD_TICKS) ? FRAME_TICKS : GUARD_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_TICKS > 0) ? (GUARD_TICKS - 1) : 0);
  localparam logic [ID_W:0]    NUM_REQ_W  = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_n;
  logic [NUM_REQ-1:0] ack_n;
  logic               start_n;
  logic               load_s;
  logic [ID_W-1:0]    base_s;
  logic               gnt_found_s;
  logic [ID_W-1:0]    gnt_id_s;
  logic [ID_W:0]      sum_s;
  logic [ID_W:0]      wrap_s;
  logic [7:0]         gnt_data_s;
  logic [NUM_REQ-1:0] gnt_onehot_s;

`ifdef UART_TX_ARB_FIXED_PRI_EN
  assign base_s = {ID_W{1'b0}};
`else
  logic [ID_W-1:0] ptr_r;
  logic [ID_W-1:0] next_ptr_s;

  assign base_s     = ptr_r;
  assign next_ptr_s = (gnt_id_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (gnt_id_s + ID_W'(1));

  // Round-robin pointer: the requester after the last grant gets top priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_r <= {ID_W{1'b0}};
    end else if (load_s) begin
      ptr_r <= next_ptr_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Search requests upward from base_s, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_id_s    = {ID_W{1'b0}};
    sum_s       = {(ID_W + 1){1'b0}};
    wrap_s      = {(ID_W + 1){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s = {1'b0, base_s} + (ID_W + 1)'(i);
      if (sum_s >= NUM_REQ_W) begin
        wrap_s = sum_s - NUM_REQ_W;
      end else begin
        wrap_s = sum_s;
      end
      if (!gnt_found_s && i_req[wrap_s[ID_W-1:0]]) begin
        gnt_found_s = 1'b1;
        gnt_id_s    = wrap_s[ID_W-1:0];
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign gnt_data_s   = i_data[{gnt_id_s, 3'b000} +: 8];
  assign gnt_onehot_s = {{(NUM_REQ - 1){1'b0}}, 1'b1} << gnt_id_s;

  // Next-state, tick counting and next output values.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    ack_n   = {NUM_REQ{1'b0}};
    start_n = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_found_s) begin
          ack_n   = gnt_onehot_s;
          load_s  = 1'b1;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        start_n = 1'b1;
        cnt_n   = {CNT_W{1'b0}};
        state_n = WAIT;
      end
      WAIT: begin
        if (i_clk_tx) begin
          if (cnt_r == FRAME_LAST) begin
            cnt_n   = {CNT_W{1'b0}};
            state_n = (GUARD_TICKS == 0) ? IDLE : GUARD;
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      GUARD: begin
        if (i_clk_tx) begin
          if (cnt_r == GUARD_LAST) begin
            cnt_n   = {CNT_W{1'b0}};
            state_n = IDLE;
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      default: begin
        cnt_n   = {CNT_W{1'b0}};
        state_n = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset also aborts a frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      o_ack      <= {NUM_REQ{1'b0}};
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'h00;
      o_busy     <= 1'b0;
      o_grant_id <= {ID_W{1'b0}};
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      o_ack      <= ack_n;
      o_tx_start <= start_n;
      o_busy     <= (state_n != IDLE);
      if (load_s) begin
        o_tx_data  <= gnt_data_s;
        o_grant_id <= gnt_id_s;
      end else begin
        o_tx_data  <= o_tx_data;
        o_grant_id <= o_grant_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default instance plus a GUARD_TICKS=0 instance.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic        i_clk_tx;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic [1:0]  o_grant_id;
  logic [3:0]  g0_ack;
  logic        g0_tx_start;
  logic [7:0]  g0_tx_data;
  logic        g0_busy;
  logic [1:0]  g0_grant_id;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_period = 1;

  int total_ticks = 0;
  int busy_ticks = 0;
  int n_acks = 0;
  int last_start = 0;
  int start_gap = 0;
  int g0_busy_ticks = 0;
  int g0_last_start = 0;
  int g0_start_gap = 0;

  uart_tx_arbiter dut (
    .clk(clk), .reset(reset), .i_clk_tx(i_clk_tx), .i_req(i_req), .i_data(i_data),
    .o_ack(o_ack), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_busy(o_busy), .o_grant_id(o_grant_id)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .FRAME_TICKS(160), .GUARD_TICKS(0)) dut_g0 (
    .clk(clk), .reset(reset), .i_clk_tx(i_clk_tx), .i_req(i_req), .i_data(i_data),
    .o_ack(g0_ack), .o_tx_start(g0_tx_start), .o_tx_data(g0_tx_data),
    .o_busy(g0_busy), .o_grant_id(g0_grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int phase;
    phase = 0;
    i_clk_tx = 1'b0;
    forever begin
      @(negedge clk);
      phase = phase + 1;
      if (phase >= tick_period) begin
        phase = 0;
        i_clk_tx = 1'b1;
      end else begin
        i_clk_tx = 1'b0;
      end
    end
  end

  // Ticks counted outside the ack/START cycle, start-to-start spacing in ticks, ack pulses.
  always @(posedge clk) begin
    if (i_clk_tx) total_ticks <= total_ticks + 1;
    if (o_busy && (o_ack == 4'b0000) && i_clk_tx) busy_ticks <= busy_ticks + 1;
    if (o_ack != 4'b0000) n_acks <= n_acks + 1;
    if (o_tx_start) begin
      start_gap  <= total_ticks - last_start;
      last_start <= total_ticks;
    end
    if (g0_busy && (g0_ack == 4'b0000) && i_clk_tx) g0_busy_ticks <= g0_busy_ticks + 1;
    if (g0_tx_start) begin
      g0_start_gap  <= total_ticks - g0_last_start;
      g0_last_start <= total_ticks;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag, input int max_cycles);
    int c;
    c = 0;
    while (o_ack === 4'b0000 && c < max_cycles) begin
      step();
      c++;
    end
    chk(tag, {31'd0, (o_ack !== 4'b0000)}, 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int c;
    c = 0;
    while (o_busy !== 1'b0 && c < max_cycles) begin
      step();
      c++;
    end
    chk(tag, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int bt0;
    int g0bt0;
    int nack0;
    int exp_id;
    reset  = 1'b0;
    i_req  = 4'b0000;
    i_data = 32'h0000_0000;
    repeat (3) step();
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_ack", {28'd0, o_ack}, 32'd0);
    chk("rst_start", {31'd0, o_tx_start}, 32'd0);
    chk("rst_data", {24'd0, o_tx_data}, 32'h00);
    chk("rst_gid", {30'd0, o_grant_id}, 32'd0);
    reset = 1'b1;
    step();

    // Single request from requester 2, ticks every third clock.
    tick_period = 3;
    step();
    bt0    = busy_ticks;
    g0bt0  = g0_busy_ticks;
    i_data = 32'h00A5_0000;
    i_req  = 4'b0100;
    step();
    chk("single_ack", {28'd0, o_ack}, 32'h4);
    chk("single_gid", {30'd0, o_grant_id}, 32'd2);
    chk("single_data", {24'd0, o_tx_data}, 32'hA5);
    chk("single_busy", {31'd0, o_busy}, 32'd1);
    chk("single_nostart", {31'd0, o_tx_start}, 32'd0);
    i_req = 4'b0000;
    step();
    chk("single_start", {31'd0, o_tx_start}, 32'd1);
    chk("single_ack_gone", {28'd0, o_ack}, 32'd0);
    step();
    chk("single_start_pulse", {31'd0, o_tx_start}, 32'd0);
    wait_idle("single_idle", 2000);
    chk("single_busy_ticks", busy_ticks - bt0, 32'd176);
    chk("single_data_held", {24'd0, o_tx_data}, 32'hA5);
    chk("g0_busy_ticks", g0_busy_ticks - g0bt0, 32'd160);

    // Round-robin with all requests held, ticks every clock.
    reset = 1'b0;
    step();
    reset = 1'b1;
    tick_period = 1;
    i_data = 32'h4433_2211;
    nack0  = n_acks;
    i_req  = 4'b1111;
    for (int k = 0; k < 5; k++) begin
`ifdef UART_TX_ARB_FIXED_PRI_EN
      exp_id = 0;
`else
      exp_id = k % 4;
`endif
      wait_ack("rr_wait_ack", 400);
      chk("rr_ack", {28'd0, o_ack}, 32'd1 << exp_id);
      chk("rr_gid", {30'd0, o_grant_id}, exp_id);
      chk("rr_data", {24'd0, o_tx_data}, 32'h11 * (exp_id + 1));
      if (k == 4) i_req = 4'b0000;
      step();
      chk("rr_start", {31'd0, o_tx_start}, 32'd1);
      step();
      if (k > 0) chk("rr_gap", start_gap, 32'd178);
    end
    wait_idle("rr_idle", 400);
    chk("rr_ack_count", n_acks - nack0, 32'd5);
    chk("g0_gap", g0_start_gap, 32'd162);

    // Late arrival: requester 1 rises while requester 0's frame is in WAIT.
    i_data = 32'h0000_C35A;
    nack0  = n_acks;
    i_req  = 4'b0001;
    wait_ack("late_wait0", 400);
    chk("late_ack0", {28'd0, o_ack}, 32'h1);
    i_req = 4'b0000;
    repeat (20) step();
    i_req = 4'b0010;
    wait_ack("late_wait1", 400);
    chk("late_ack1", {28'd0, o_ack}, 32'h2);
    chk("late_gid", {30'd0, o_grant_id}, 32'd1);
    chk("late_data", {24'd0, o_tx_data}, 32'hC3);
    chk("late_no_early_ack", n_acks - nack0, 32'd1);
    i_req = 4'b0000;
    step();
    step();
    chk("late_gap", start_gap, 32'd178);
    wait_idle("late_idle", 400);

    // Reset mid-frame with requester 3 pending.
    i_data = 32'h0099_0000;
    i_req  = 4'b0100;
    wait_ack("mrst_wait", 400);
    i_data = 32'h7700_0000;
    i_req  = 4'b1000;
    repeat (30) step();
    reset = 1'b0;
    step();
    chk("mrst_busy", {31'd0, o_busy}, 32'd0);
    chk("mrst_data", {24'd0, o_tx_data}, 32'h00);
    chk("mrst_ack", {28'd0, o_ack}, 32'd0);
    chk("mrst_start", {31'd0, o_tx_start}, 32'd0);
    chk("mrst_gid", {30'd0, o_grant_id}, 32'd0);
    reset = 1'b1;
    step();
    chk("mrst_ack3", {28'd0, o_ack}, 32'h8);
    chk("mrst_gid3", {30'd0, o_grant_id}, 32'd3);
    chk("mrst_data3", {24'd0, o_tx_data}, 32'h77);
    i_req = 4'b0000;
    wait_idle("mrst_idle", 400);

    // Pointer returns to 0 on reset: requesters 0 and 3 pending, 0 must win.
    i_req = 4'b0010;
    wait_ack("ptr_wait", 400);
    i_data = 32'h7700_00E1;
    i_req  = 4'b1001;
    repeat (30) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("ptr_ack0", {28'd0, o_ack}, 32'h1);
    chk("ptr_gid0", {30'd0, o_grant_id}, 32'd0);
    chk("ptr_data0", {24'd0, o_tx_data}, 32'hE1);
    i_req = 4'b0000;
    wait_idle("ptr_idle", 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
